// File: rtl/candy_if_pkg.sv
// Shared defaults and sizing helpers for the candy fetch stage.
package candy_if_pkg;

    localparam int PC_WIDTH_DEF   = 16;
    localparam int INST_WIDTH_DEF = 24;
    localparam int FIFO_DEPTH_DEF = 2;

    // Bits needed to hold a count in the range 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/candy_if_fifo.sv
// Shift-register prefetch FIFO: entry 0 is always the head, so the head,
// its valid bit and the data are all plain registers.
module candy_if_fifo
    import candy_if_pkg::*;
#(
    parameter int WIDTH = 40,
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        flush,
    input  logic [WIDTH-1:0]            din,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        empty,
    output logic                        full,
    output logic [WIDTH-1:0]            head
);

    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic             placed;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        placed  = 1'b0;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (pop && valid_q[0]) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    data_d[i]  = data_q[i+1];
                    valid_d[i] = valid_q[i+1];
                end
                valid_d[DEPTH-1] = 1'b0;
            end
            // Write into the first free slot after the shift, so push+pop on full works.
            if (push) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (!placed && !valid_d[i]) begin
                        data_d[i]  = din;
                        valid_d[i] = 1'b1;
                        placed     = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count = count + CW'(valid_q[i]);
        end
    end

    assign empty = !valid_q[0];
    assign full  = valid_q[DEPTH-1];
    assign head  = data_q[0];

endmodule

// File: rtl/candy_if.sv
// Instruction fetch stage: PC, in-order imem request/response tracking with
// credit-based issue, redirect flush and a prefetch FIFO feeding candy_id.
module candy_if
    import candy_if_pkg::*;
#(
    parameter int                  PC_WIDTH   = PC_WIDTH_DEF,
    parameter int                  INST_WIDTH = INST_WIDTH_DEF,
    parameter int                  FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [INST_WIDTH-1:0] imem_rdata,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [PC_WIDTH-1:0]   redirect_pc,
    output logic [INST_WIDTH-1:0] inst,
    output logic [PC_WIDTH-1:0]   inst_pc,
    output logic                  id_enable
);

    localparam int CW = cnt_width(FIFO_DEPTH);
    localparam int EW = PC_WIDTH + INST_WIDTH;

    logic [PC_WIDTH-1:0] pc;
    logic [PC_WIDTH-1:0] deliver_pc;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       discard;
    logic [CW-1:0]       outstanding_next;
    logic [CW-1:0]       live;
    logic [CW-1:0]       fifo_count;
    logic [CW:0]         occupancy;
    logic                resp;
    logic                grant;
    logic                push;
    logic                pop;
    logic                fifo_empty;
    logic                fifo_full;
    logic [EW-1:0]       fifo_head;

    // Handshakes: a request transfers on a cycle with imem_req && imem_gnt;
    // imem_addr is held while req waits for gnt. A response is one imem_rvalid
    // cycle, in order. The decoder consumes inst when id_enable && !stall.
    assign resp      = imem_rvalid && (outstanding != '0);
    assign live      = outstanding - discard;
    assign occupancy = {1'b0, live} + {1'b0, fifo_count};
    // rst gating keeps req low for the whole asynchronous reset window.
    assign imem_req  = rst && !redirect_valid
                     && (outstanding < CW'(FIFO_DEPTH))
                     && (occupancy < (CW+1)'(FIFO_DEPTH));
    assign imem_addr = pc;
    assign grant     = imem_req && imem_gnt;

    assign outstanding_next = outstanding + CW'(grant) - CW'(resp);
    assign push = resp && !redirect_valid && (discard == '0);
    assign pop  = !fifo_empty && !stall && !redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            deliver_pc  <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect_valid) begin
                pc         <= redirect_pc;
                deliver_pc <= redirect_pc;
                discard    <= outstanding_next;
            end else begin
                if (grant) begin
                    pc <= pc + PC_WIDTH'(1);
                end
                if (resp) begin
                    if (discard != '0) begin
                        discard <= discard - CW'(1);
                    end else begin
                        deliver_pc <= deliver_pc + PC_WIDTH'(1);
                    end
                end
            end
        end
    end

    candy_if_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   ({deliver_pc, imem_rdata}),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full),
        .head  (fifo_head)
    );

    assign inst      = fifo_head[INST_WIDTH-1:0];
    assign inst_pc   = fifo_head[EW-1:INST_WIDTH];
    assign id_enable = !fifo_empty;

    a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (!rst)
        imem_rvalid |-> (outstanding != '0));
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        !(push && fifo_full && !pop));

endmodule

// File: tb/tb_candy_if.sv
// Bench for candy_if: directed scenarios then random traffic, checked against
// a queue-based model of requests in flight and the prefetch FIFO.
module tb_candy_if;

    localparam int DEPTH = 2;

    typedef struct {
        logic [15:0] addr;
        bit          stale;
        int          born;
    } flight_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [23:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;

    logic        imem_req, w_req;
    logic [15:0] imem_addr, w_addr;
    logic [23:0] inst, w_inst;
    logic [15:0] inst_pc, w_inst_pc;
    logic        id_enable, w_id_enable;

    flight_t     inflight[$];
    logic [39:0] exp_q[$];
    logic [15:0] pc_m;
    logic        exp_req;
    logic        resp_now;
    int          cyc;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    candy_if dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst(inst), .inst_pc(inst_pc), .id_enable(id_enable)
    );

    // Lockstep twin starting at FFFF: same handshakes, addresses offset by -1.
    candy_if #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst(w_inst), .inst_pc(w_inst_pc), .id_enable(w_id_enable)
    );

    function automatic logic [23:0] word_for(input logic [15:0] a);
        case (a)
            16'd0:   return 24'h027890;
            16'd1:   return 24'h478900;
            16'd2:   return 24'h878900;
            16'd3:   return 24'hc78900;
            default: return {a[7:0] ^ 8'hA5, a};
        endcase
    endfunction

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        inflight.delete();
        pc_m = 16'h0000;
    endtask

    // Apply one cycle of inputs and compare outputs with the model.
    task automatic drive(input logic g, input logic want_rv, input logic s,
                         input logic rd, input logic [15:0] rpc);
        int live;
        imem_gnt       = g;
        stall          = s;
        redirect_valid = rd;
        redirect_pc    = rpc;
        resp_now       = want_rv && (inflight.size() > 0) && (inflight[0].born < cyc);
        imem_rvalid    = resp_now;
        imem_rdata     = resp_now ? word_for(inflight[0].addr) : 24'($urandom);
        #1;
        live = 0;
        foreach (inflight[i]) if (!inflight[i].stale) live++;
        exp_req = !rd && (inflight.size() < DEPTH) && (live + exp_q.size() < DEPTH);
        check("imem_req", imem_req, exp_req);
        check("imem_addr", imem_addr, pc_m);
        check("id_enable", id_enable, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check("inst", inst, exp_q[0][23:0]);
            check("inst_pc", inst_pc, exp_q[0][39:24]);
        end
    endtask

    // Commit this cycle's effects to the model and move past the clock edge.
    task automatic advance();
        flight_t e;
        bit      have;
        have = 1'b0;
        if (resp_now) begin
            e    = inflight.pop_front();
            have = 1'b1;
        end
        if (redirect_valid) begin
            exp_q.delete();
            foreach (inflight[i]) inflight[i].stale = 1'b1;
            pc_m = redirect_pc;
        end else begin
            if (exp_q.size() > 0 && !stall) void'(exp_q.pop_front());
            if (have && !e.stale) exp_q.push_back({e.addr, word_for(e.addr)});
            if (exp_req && imem_gnt) begin
                inflight.push_back('{pc_m, 1'b0, cyc});
                pc_m = pc_m + 16'd1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (inflight.size() != 0 || exp_q.size() != 0) begin
                drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
                advance();
            end
        end
    endtask

    initial begin
        logic [15:0] saved;
        logic [15:0] rpc;
        bit          found;

        cyc = 0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_id_enable", id_enable, 1'b0);
        check("rst_req", imem_req, 1'b0);
        check("rst_inst", inst, 24'h0);
        check("rst_inst_pc", inst_pc, 16'h0);
        check("rst_addr", imem_addr, 16'h0000);
        check("rst_wrap_addr", w_addr, 16'hFFFF);
        rst = 1'b1;

        // Streaming fetch with immediate grant and next-cycle response.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
            if (i == 0) check("wrap_addr0", w_addr, 16'hFFFF);
            if (i == 1) check("wrap_addr1", w_addr, 16'h0000);
            if (i == 2) begin
                check("first_id_enable", id_enable, 1'b1);
                check("first_inst_pc", inst_pc, 16'h0000);
                check("wrap_inst_pc0", w_inst_pc, 16'hFFFF);
            end
            if (i == 3) check("wrap_inst_pc1", w_inst_pc, 16'h0000);
            advance();
        end

        // Asynchronous reset pulsed between edges.
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_id_enable", id_enable, 1'b0);
        check("arst_req", imem_req, 1'b0);
        check("arst_inst", inst, 24'h0);
        check("arst_wrap_req", w_req, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;

        // Stall from restart: FIFO fills with pc 0 and 1, issue stops.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
            if (i == 0) check("restart_addr", imem_addr, 16'h0000);
            if (i >= 3) begin
                check("stall_inst", inst, 24'h027890);
                check("stall_req", imem_req, 1'b0);
            end
            advance();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        advance();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("unstall_inst_pc", inst_pc, 16'h0001);
        check("unstall_inst", inst, 24'h478900);
        advance();
        drain();

        // Redirect with two fetches in flight.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        advance();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        advance();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0040);
        check("redir_req_low", imem_req, 1'b0);
        advance();
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
            if (i == 0) check("redir_addr", imem_addr, 16'h0040);
            if (id_enable) begin
                found = 1'b1;
                check("redir_inst_pc", inst_pc, 16'h0040);
                check("redir_inst", inst, word_for(16'h0040));
            end
            advance();
        end
        check("redir_delivered", found, 1'b1);
        drain();

        // Slow memory: grant withheld for three cycles.
        saved = pc_m;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
            check("slow_addr", imem_addr, saved);
            check("slow_req", imem_req, 1'b1);
            advance();
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        advance();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
        check("slow_advance", imem_addr, 16'(saved + 16'd1));
        advance();
        drain();

        // Random traffic, including back-to-back redirects and wrap targets.
        for (int i = 0; i < 1500; i++) begin
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, rpc);
            advance();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
